output_block_vc: RTL

Per-output-port transmit side of the credit-based virtual-channel link. Registers flits leaving the switch onto the link toward the downstream router and tracks one credit counter per downstream VC. Runs a per-VC ownership state machine that gates reuse of a downstream VC until its packet has drained. Feeds `ovc_credits_count_r` and `out_vc_free` back to the router's route-compute and VC-allocation stages.

---
 rtl/output_block_vc.sv | 112 +++++++++++
 1 files changed

// File: rtl/output_block_vc.sv
// rtl/output_block_vc.sv - Per-output-port link transmit stage with per-VC credit counters and ownership FSM.
// Router-wide channel types and sizing live in router_pkg, kept alongside the block that uses them.
package router_pkg;
  localparam int NUM_VCS          = 4;
  localparam int CREDITS_PER_VC   = 4;
  localparam int CREDIT_CTR_WIDTH = 3;
  localparam int VC_ID_BITS       = 3;
  localparam int DATA_WIDTH       = 16;

  typedef enum logic [2:0] {I = 3'd0, H = 3'd1, B = 3'd2, T = 3'd3, HT = 3'd4} ftype_t;

  typedef struct packed {
    ftype_t                  ftype;
    logic [VC_ID_BITS-1:0]   fvcid;
    logic [DATA_WIDTH-1:0]   data;
  } channel_t;
endpackage

module output_block_vc #(
  parameter int NUM_VCS          = router_pkg::NUM_VCS,
  parameter int CREDITS_PER_VC   = router_pkg::CREDITS_PER_VC,
  parameter int CREDIT_CTR_WIDTH = router_pkg::CREDIT_CTR_WIDTH,
  parameter int VC_ID_BITS       = router_pkg::VC_ID_BITS,
  parameter bit ASSERT_EN        = 1'b1
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  router_pkg::channel_t                       inflit,
  input  logic                                       credit_in_valid,
  input  logic [VC_ID_BITS-1:0]                      credit_in_vcid,
  input  logic [NUM_VCS-1:0]                         va_grant,
  output router_pkg::channel_t                       outflit,
  output logic [NUM_VCS-1:0][CREDIT_CTR_WIDTH-1:0]   ovc_credits_count_r,
  output logic [NUM_VCS-1:0]                         out_vc_free,
  output logic                                       credit_err
);

  typedef enum logic [1:0] {S_FREE, S_ALLOC, S_DRAIN} vc_state_e;

  localparam logic [CREDIT_CTR_WIDTH-1:0] FULL = CREDIT_CTR_WIDTH'(CREDITS_PER_VC);

  vc_state_e          state [NUM_VCS];
  logic               flit_valid, vc_in_range, is_tail, range_err;
  logic [NUM_VCS-1:0] send, ret, underflow, overflow, free_send, bad_grant;

  always_comb begin
    flit_valid  = inflit.ftype != router_pkg::I;
    vc_in_range = int'(inflit.fvcid) < NUM_VCS;
    is_tail     = (inflit.ftype == router_pkg::T) || (inflit.ftype == router_pkg::HT);
    range_err   = flit_valid && !vc_in_range;
    send        = '0;
    ret         = '0;
    underflow   = '0;
    overflow    = '0;
    free_send   = '0;
    bad_grant   = '0;
    out_vc_free = '0;
    for (int n = 0; n < NUM_VCS; n++) begin
      send[n]        = flit_valid && vc_in_range && (int'(inflit.fvcid) == n);
      ret[n]         = credit_in_valid && (int'(credit_in_vcid) == n);
      underflow[n]   = send[n] && (ovc_credits_count_r[n] == '0);
      overflow[n]    = ret[n] && !send[n] && (ovc_credits_count_r[n] == FULL);
      free_send[n]   = send[n] && (state[n] == S_FREE);
      bad_grant[n]   = va_grant[n] && (state[n] != S_FREE);
      out_vc_free[n] = state[n] == S_FREE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outflit    <= '0;
      credit_err <= 1'b0;
      for (int n = 0; n < NUM_VCS; n++) begin
        ovc_credits_count_r[n] <= FULL;
        state[n]               <= S_FREE;
      end
    end else begin
      outflit <= inflit;
      if (range_err || (|underflow) || (|overflow) || (|free_send) || (|bad_grant))
        credit_err <= 1'b1;
      for (int n = 0; n < NUM_VCS; n++) begin
        // Saturate at both ends; the violation is reported through credit_err instead.
        if (send[n] && !ret[n] && !underflow[n])
          ovc_credits_count_r[n] <= ovc_credits_count_r[n] - 1'b1;
        else if (ret[n] && !send[n] && !overflow[n])
          ovc_credits_count_r[n] <= ovc_credits_count_r[n] + 1'b1;

        case (state[n])
          S_FREE:  if (va_grant[n]) state[n] <= S_ALLOC;
          S_ALLOC: if (send[n] && is_tail) state[n] <= S_DRAIN;
          S_DRAIN: if (ovc_credits_count_r[n] == FULL && !send[n]) state[n] <= S_FREE;
          default: state[n] <= S_FREE;
        endcase
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (ASSERT_EN && !rst) begin
      for (int n = 0; n < NUM_VCS; n++) begin
        assert (!underflow[n]) else $error("credit underflow on vc %0d", n);
        assert (!overflow[n])  else $error("credit overflow on vc %0d", n);
        assert (!free_send[n]) else $error("flit sent on unowned vc %0d", n);
        assert (!bad_grant[n]) else $error("grant on busy vc %0d", n);
      end
      assert (!range_err) else $error("flit on out-of-range vc %0d", inflit.fvcid);
    end
  end
`endif

endmodule
